mp_add_seq: RTL and testbench

Multi-precision add sequencer that reuses the team's 16-bit adder, `operation16`, one word per clock to add two WORDS×16-bit operands. The block latches both operands on a start request and walks the words LSW-first, feeding the registered carry of each word into the next. It presents the full-width sum and final carry-out with a one-cycle done pulse. It sits between a requesting controller and the single shared 16-bit adder datapath.

---
 rtl/mp_add_pkg.sv | 20 ++
 rtl/mp_add_seq_operation16.sv | 13 +
 rtl/mp_add_seq.sv | 124 ++++++++++++
 tb/tb_mp_add_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mp_add_pkg.sv
// Shared constants, state encoding and sizing helper for the multi-precision add sequencer.
package mp_add_pkg;

    localparam int unsigned WORD_W = 16;

    // Legacy-compatible state encoding: constants rather than an enum type
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Width of the word index counter; never narrower than one bit
    function automatic int unsigned idx_width(input int unsigned words);
        if (words <= 2) begin
            return 1;
        end
        return $clog2(words);
    endfunction

endpackage

// File: rtl/mp_add_seq_operation16.sv
// operation16: the shared 16-bit adder, e1 + e2 + r0 -> {r1, s}. Purely combinational.
module operation16 (
    input  logic [15:0] e1,
    input  logic [15:0] e2,
    input  logic        r0,
    output logic [15:0] s,
    output logic        r1
);

    // Single 17-bit addition; the top bit is the carry-out
    assign {r1, s} = {1'b0, e1} + {1'b0, e2} + {16'd0, r0};

endmodule

// File: rtl/mp_add_seq.sv
// mp_add_seq: adds two WORDS x 16-bit operands one word per clock through operation16,
// LSW first, with the carry registered between words. A one-cycle done pulse marks a
// fresh sum/cout.
// Optional feature: define MP_ADD_SUB_EN to add a 'sub' input that selects A - B.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WORD_W*WORDS-1:0] a,
    input  logic [WORD_W*WORDS-1:0] b,
    input  logic                    cin,
`ifdef MP_ADD_SUB_EN
    input  logic                    sub,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [WORD_W*WORDS-1:0] sum,
    output logic                    cout
);

    localparam int unsigned W  = WORD_W * WORDS;
    localparam int unsigned IW = idx_width(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [W-1:0]    a_sr;
    logic [W-1:0]    b_sr;
    logic            carry_q;
    logic [W-1:0]    acc_q;
    logic [W-1:0]    sum_q;
    logic            cout_q;
    logic            sub_q;

    logic [WORD_W-1:0] add_e2;
    logic [WORD_W-1:0] add_s;
    logic              add_r1;
    logic [W-1:0]      acc_next;
    logic              carry_init;

`ifdef MP_ADD_SUB_EN
    // Subtraction is A + ~B + 1: invert each B word and force the initial carry
    assign add_e2     = sub_q ? ~b_sr[WORD_W-1:0] : b_sr[WORD_W-1:0];
    assign carry_init = sub ? 1'b1 : cin;
`else
    assign add_e2     = b_sr[WORD_W-1:0];
    assign carry_init = cin;
`endif

    operation16 u_add (
        .e1 (a_sr[WORD_W-1:0]),
        .e2 (add_e2),
        .r0 (carry_q),
        .s  (add_s),
        .r1 (add_r1)
    );

    // New word enters at the top so the LSW ends up at the bottom after WORDS shifts
    if (WORDS == 1) begin : g_acc_one
        assign acc_next = add_s;
    end else begin : g_acc_multi
        assign acc_next = {add_s, acc_q[W-1:WORD_W]};
    end

    // FSM, word counter, operand shift registers and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        carry_q <= carry_init;
                        idx_q   <= '0;
`ifdef MP_ADD_SUB_EN
                        sub_q   <= sub;
`endif
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_next;
                    a_sr    <= a_sr >> WORD_W;
                    b_sr    <= b_sr >> WORD_W;
                    carry_q <= add_r1;
                    if (idx_q == LAST) begin
                        idx_q   <= '0;
                        sum_q   <= acc_next;
                        cout_q  <= add_r1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q == RUN) || (state_q == DONE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Testbench for mp_add_seq: directed corner cases plus randomized operands checked
// against a plain-arithmetic model ({cout,sum} = a + b + cin, or a - b when subtracting).
module tb_mp_add_seq;

    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_vec = 0;
    int n_bad = 0;

    mp_add_seq #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef MP_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
        if (s) begin
            return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        end
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        v = {$urandom, $urandom};
        return v;
    endfunction

    // One complete transaction from an idle DUT; returns at a negedge with the DUT idle
    task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xc, input logic xs);
        logic [W:0]   exp;
        logic [W-1:0] held;
        int lat;
        exp = model(xa, xb, xc, xs);
        @(negedge clk);
        start = 1'b1;
        a = xa;
        b = xb;
        cin = xc;
        sub = xs;
        @(negedge clk);
        // Scramble inputs: the operation must use only the latched operands
        start = 1'b0;
        a = rand_w();
        b = rand_w();
        cin = ~xc;
        sub = ~xs;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, (W+1)'(lat), (W+1)'(WORDS + 1));
        check({tag, " sum"}, {1'b0, sum}, {1'b0, exp[W-1:0]});
        check({tag, " cout"}, {{W{1'b0}}, cout}, {{W{1'b0}}, exp[W]});
        check({tag, " busy"}, {{W{1'b0}}, busy}, (W+1)'(1));
        held = sum;
        @(negedge clk);
        check({tag, " done pulse"}, {{W{1'b0}}, done}, '0);
        check({tag, " sum hold"}, {1'b0, sum}, {1'b0, held});
    endtask

    logic [W-1:0] opa[30];
    logic [W-1:0] opb[30];
    logic         opc[30];
    logic [W:0]   e;
    int           n_done;

    initial begin
        // Reset held with start high
        rst = 1'b1;
        start = 1'b1;
        a = rand_w();
        b = rand_w();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset busy", {{W{1'b0}}, busy}, '0);
            check("reset done", {{W{1'b0}}, done}, '0);
            check("reset sum", {1'b0, sum}, '0);
            check("reset cout", {{W{1'b0}}, cout}, '0);
        end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("post-reset busy", {{W{1'b0}}, busy}, '0);
        check("post-reset sum", {1'b0, sum}, '0);

        run_op("ripple", 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        check("ripple const", {cout, sum}, {1'b1, 64'h0});
        run_op("mixed", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1, 1'b0);
        check("mixed const", {cout, sum}, {1'b0, 64'h2345_6789_ABCD_F002});
        run_op("allones", '1, '1, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("rand%0d", i), rand_w(), rand_w(), 1'($urandom), 1'b0);
        end

        // Start held high with operands changing every cycle
        n_done = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            check($sformatf("held done n%0d", n), {{W{1'b0}}, done},
                  (W+1)'((n % 6) == 5));
            if (done) begin
                n_done++;
                if (n >= 5) begin
                    e = model(opa[n-5], opb[n-5], opc[n-5], 1'b0);
                    check($sformatf("held result n%0d", n), {cout, sum}, e);
                end
            end
            opa[n] = rand_w();
            opb[n] = rand_w();
            opc[n] = 1'($urandom);
            start = 1'b1;
            a = opa[n];
            b = opb[n];
            cin = opc[n];
            sub = 1'b0;
        end
        start = 1'b0;
        check("held done count", (W+1)'(n_done), (W+1)'(5));

        // Reset in RUN with idx=2 while a carry is pending
        @(negedge clk);
        start = 1'b1;
        a = '1;
        b = 64'h1;
        cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid busy before rst", {{W{1'b0}}, busy}, (W+1)'(1));
        rst = 1'b1;
        @(negedge clk);
        check("mid rst busy", {{W{1'b0}}, busy}, '0);
        check("mid rst done", {{W{1'b0}}, done}, '0);
        check("mid rst sum", {1'b0, sum}, '0);
        check("mid rst cout", {{W{1'b0}}, cout}, '0);
        rst = 1'b0;
        run_op("after rst", 64'd3, 64'd4, 1'b0, 1'b0);
        check("after rst const", {cout, sum}, {1'b0, 64'd7});

`ifdef MP_ADD_SUB_EN
        run_op("sub 5-7", 64'd5, 64'd7, 1'b0, 1'b1);
        check("sub 5-7 const", {cout, sum}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
        run_op("sub 7-5", 64'd7, 64'd5, 1'b1, 1'b1);
        check("sub 7-5 const", {cout, sum}, {1'b1, 64'd2});
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("rsub%0d", i), rand_w(), rand_w(), 1'($urandom), 1'($urandom));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
